// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bridge engines (reader, poster, bridge top).
// Holds the bus FSM state set, default strobe timings and width helpers.
package lcd_pkg;

    localparam int unsigned LCD_DATA_W  = 16;
    localparam int unsigned WR_LOW_DEF  = 2;
    localparam int unsigned WR_HIGH_DEF = 2;
    localparam int unsigned RD_LOW_DEF  = 4;
    localparam int unsigned RD_HIGH_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD_LO,
        CMD_HI,
        TURN,
        RD_LO,
        RD_HI,
        DONE
    } lcd_state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold values 0..v (at least 1).
    function automatic int unsigned bits_for(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(v)) w++;
        return w;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down counter used to time each bus phase; zero_o flags the last cycle of a phase.
// Counter width is derived from the largest value it must hold.
module lcd_phase_timer
    import lcd_pkg::*;
#(
    parameter int unsigned MAX_VAL = 3,
    parameter int unsigned W       = bits_for(MAX_VAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// Read-side engine of the 8080-style LCD bus: one command write followed by N read strobes,
// returning sampled panel words to the CPU side. All outputs are registered.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned WR_LOW  = WR_LOW_DEF,
    parameter int unsigned WR_HIGH = WR_HIGH_DEF,
    parameter int unsigned RD_LOW  = RD_LOW_DEF,
    parameter int unsigned RD_HIGH = RD_HIGH_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LCD_DATA_W-1:0] req_cmd,
    input  logic [CNT_W-1:0]      req_count,
    input  logic                  req_dummy,
    output logic [LCD_DATA_W-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  busy,
    output logic                  lcd_cs,
    output logic                  lcd_rs,
    output logic                  lcd_wr,
    output logic                  lcd_rd,
    output logic [LCD_DATA_W-1:0] lcd_data_o,
    output logic                  lcd_data_oe,
    input  logic [LCD_DATA_W-1:0] lcd_data_i
);

    localparam int unsigned T_MAX = max4(WR_LOW, WR_HIGH, RD_LOW, RD_HIGH) - 1;
    localparam int unsigned TW    = bits_for(T_MAX);

    localparam logic [TW-1:0] T_WR_LO = TW'(WR_LOW - 1);
    localparam logic [TW-1:0] T_WR_HI = TW'(WR_HIGH - 1);
    localparam logic [TW-1:0] T_RD_LO = TW'(RD_LOW - 1);
    localparam logic [TW-1:0] T_RD_HI = TW'(RD_HIGH - 1);

    lcd_state_e            state_q, state_d;
    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_zero;
    logic                  accept;
    logic                  strobe_end;

    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic                  dummy_pend_q, dummy_pend_d;

    logic                  lcd_cs_q, lcd_cs_d;
    logic                  lcd_rs_q, lcd_rs_d;
    logic                  lcd_wr_q, lcd_wr_d;
    logic                  lcd_rd_q, lcd_rd_d;
    logic                  oe_q, oe_d;
    logic [LCD_DATA_W-1:0] data_o_q, data_o_d;
    logic [LCD_DATA_W-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  req_ready_q, req_ready_d;

    lcd_phase_timer #(
        .MAX_VAL (T_MAX),
        .W       (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        accept     = 1'b0;
        strobe_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    state_d  = CMD_LO;
                    tmr_load = 1'b1;
                    tmr_val  = T_WR_LO;
                end
            end
            CMD_LO: begin
                if (tmr_zero) begin
                    state_d  = CMD_HI;
                    tmr_load = 1'b1;
                    tmr_val  = T_WR_HI;
                end
            end
            CMD_HI: begin
                if (tmr_zero) state_d = TURN;
            end
            TURN: begin
                if (rd_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = RD_LO;
                    tmr_load = 1'b1;
                    tmr_val  = T_RD_LO;
                end
            end
            RD_LO: begin
                if (tmr_zero) begin
                    strobe_end = 1'b1;
                    state_d    = RD_HI;
                    tmr_load   = 1'b1;
                    tmr_val    = T_RD_HI;
                end
            end
            RD_HI: begin
                // rd_cnt_q was already decremented when the preceding strobe ended
                if (tmr_zero) begin
                    if (rd_cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RD_LO;
                        tmr_load = 1'b1;
                        tmr_val  = T_RD_LO;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_cnt_d      = rd_cnt_q;
        dummy_pend_d  = dummy_pend_q;
        if (accept) begin
            rd_cnt_d     = req_count;
            dummy_pend_d = req_dummy;
        end else if (strobe_end) begin
            rd_cnt_d     = rd_cnt_q - CNT_W'(1);
            dummy_pend_d = 1'b0;
        end

        // Outputs follow the next state so they line up with the state register.
        lcd_cs_d      = (state_d == IDLE) || (state_d == DONE);
        lcd_rs_d      = !((state_d == CMD_LO) || (state_d == CMD_HI));
        lcd_wr_d      = (state_d != CMD_LO);
        lcd_rd_d      = (state_d != RD_LO);
        oe_d          = (state_d == CMD_LO) || (state_d == CMD_HI);
        data_o_d      = accept ? req_cmd : (oe_d ? data_o_q : '0);
        rdata_valid_d = strobe_end && !dummy_pend_q;
        rdata_d       = rdata_valid_d ? lcd_data_i : rdata_q;
        done_d        = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        req_ready_d   = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_cnt_q      <= '0;
            dummy_pend_q  <= 1'b0;
            lcd_cs_q      <= 1'b1;
            lcd_rs_q      <= 1'b1;
            lcd_wr_q      <= 1'b1;
            lcd_rd_q      <= 1'b1;
            oe_q          <= 1'b0;
            data_o_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            req_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            dummy_pend_q  <= dummy_pend_d;
            lcd_cs_q      <= lcd_cs_d;
            lcd_rs_q      <= lcd_rs_d;
            lcd_wr_q      <= lcd_wr_d;
            lcd_rd_q      <= lcd_rd_d;
            oe_q          <= oe_d;
            data_o_q      <= data_o_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            req_ready_q   <= req_ready_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign lcd_cs      = lcd_cs_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_wr      = lcd_wr_q;
    assign lcd_rd      = lcd_rd_q;
    assign lcd_data_o  = data_o_q;
    assign lcd_data_oe = oe_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: panel model on the read strobe, bus protocol monitor,
// and one task per scenario with hand-computed expectations.
module tb_lcd_reader;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_cmd = '0;
    logic [3:0]  req_count = '0;
    logic        req_dummy = 1'b0;
    logic [15:0] rdata;
    logic        rdata_valid, done, busy;
    logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_oe;
    logic [15:0] lcd_data_o;
    logic [15:0] lcd_data_i = '0;

    lcd_reader #(
        .WR_LOW  (2),
        .WR_HIGH (2),
        .RD_LOW  (4),
        .RD_HIGH (4),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_count   (req_count),
        .req_dummy   (req_dummy),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .busy        (busy),
        .lcd_cs      (lcd_cs),
        .lcd_rs      (lcd_rs),
        .lcd_wr      (lcd_wr),
        .lcd_rd      (lcd_rd),
        .lcd_data_o  (lcd_data_o),
        .lcd_data_oe (lcd_data_oe),
        .lcd_data_i  (lcd_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        clr_req = 1'b0;
    logic [15:0] panel_mem [16];
    int          panel_idx = 0;

    // Panel: puts the next word on the bus when a read strobe falls.
    always @(negedge lcd_rd or posedge clr_req) begin
        if (clr_req) begin
            panel_idx = 0;
        end else if (!reset) begin
            lcd_data_i = panel_mem[panel_idx % 16];
            panel_idx++;
        end
    end

    logic [15:0] got_q[$];
    logic [15:0] wr_data_q[$];
    int          acc_q[$];
    int          done_q[$];
    int wr_pulses, rd_pulses, wr_run, rd_run;
    int viol_oe, viol_wrrd, viol_cs, viol_rs, viol_len;

    always @(negedge clk) begin
        if (clr_req || reset) begin
            if (clr_req) begin
                got_q.delete(); wr_data_q.delete(); acc_q.delete(); done_q.delete();
                wr_pulses = 0; rd_pulses = 0;
                viol_oe = 0; viol_wrrd = 0; viol_cs = 0; viol_rs = 0; viol_len = 0;
            end
            wr_run = 0;
            rd_run = 0;
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (rdata_valid) got_q.push_back(rdata);
            if (done) done_q.push_back(cyc);
            if (lcd_data_oe && !lcd_rd) viol_oe++;
            if (!lcd_wr && !lcd_rd) viol_wrrd++;
            if (busy && !done && lcd_cs) viol_cs++;
            if (!lcd_wr) begin
                if (wr_run == 0) wr_data_q.push_back(lcd_data_o);
                if (lcd_rs) viol_rs++;
                wr_run++;
            end else if (wr_run != 0) begin
                if (wr_run != 2) viol_len++;
                wr_pulses++;
                wr_run = 0;
            end
            if (!lcd_rd) begin
                rd_run++;
            end else if (rd_run != 0) begin
                if (rd_run != 4) viol_len++;
                rd_pulses++;
                rd_run = 0;
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        #1 clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic issue(input logic [15:0] cmd, input logic [3:0] cnt, input logic dmy);
        int n;
        @(posedge clk);
        #1;
        req_cmd = cmd; req_count = cnt; req_dummy = dmy; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int want, input int budget);
        int n;
        n = 0;
        while (done_q.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_q.size() < want) begin
            errors++;
            $display("FAIL done_timeout: done pulses=%0d required %0d", done_q.size(), want);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_oe, rdata_valid, done, busy, req_ready}
                !== 9'b1111_0000_1) begin
            errors++;
            $display("FAIL reset_ctrl: cs,rs,wr,rd,oe,rv,done,busy,ready=%b required 111100001",
                     {lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_oe, rdata_valid, done, busy, req_ready});
        end
        checks++;
        if (lcd_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data_o: got %h required 0000", lcd_data_o);
        end
        checks++;
        if (rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 0000", rdata);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        for (int i = 0; i < 16; i++) panel_mem[i] = 16'hA500 + 16'(i);
        clear_mon();
        issue(16'h00D3, 4'd2, 1'b0);
        n = 0;
        while (lcd_rd && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (lcd_rd !== 1'b0) begin
            errors++;
            $display("FAIL abort_reach_rd: lcd_rd=%b required 0", lcd_rd);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({lcd_rd, lcd_cs, lcd_data_oe, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL abort_immediate: rd,cs,oe,busy=%b required 1100",
                     {lcd_rd, lcd_cs, lcd_data_oe, busy});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (done_q.size() != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_done: done=%0d words=%0d required 0 0",
                     done_q.size(), got_q.size());
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_read_dummy();
        logic [15:0] exp_w [3];
        logic [15:0] obs;
        int          delta;
        exp_w[0] = 16'h0093; exp_w[1] = 16'h0093; exp_w[2] = 16'h4100;
        panel_mem[0] = 16'h0000; panel_mem[1] = 16'h0093;
        panel_mem[2] = 16'h0093; panel_mem[3] = 16'h4100;
        clear_mon();
        issue(16'h00D3, 4'd4, 1'b1);
        wait_done(1, 80);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL read_word_count: got %0d required 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            obs = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            checks++;
            if (obs !== exp_w[i]) begin
                errors++;
                $display("FAIL read_word%0d: got %h required %h", i, obs, exp_w[i]);
            end
        end
        delta = (done_q.size() > 0 && acc_q.size() > 0) ? done_q[0] - acc_q[0] : -1;
        checks++;
        if (delta != 38) begin
            errors++;
            $display("FAIL read_latency: got %0d required 38", delta);
        end
        checks++;
        if (rd_pulses != 4 || wr_pulses != 1) begin
            errors++;
            $display("FAIL read_pulses: rd=%0d wr=%0d required 4 1", rd_pulses, wr_pulses);
        end
        checks++;
        if (viol_oe + viol_wrrd + viol_cs + viol_rs + viol_len != 0) begin
            errors++;
            $display("FAIL read_protocol: oe=%0d wrrd=%0d cs=%0d rs=%0d len=%0d required all 0",
                     viol_oe, viol_wrrd, viol_cs, viol_rs, viol_len);
        end
    endtask

    task automatic test_cmd_only();
        int          delta;
        logic [15:0] wd;
        clear_mon();
        issue(16'h0029, 4'd0, 1'b0);
        wait_done(1, 30);
        delta = (done_q.size() > 0 && acc_q.size() > 0) ? done_q[0] - acc_q[0] : -1;
        checks++;
        if (delta != 6) begin
            errors++;
            $display("FAIL cmd_latency: got %0d required 6", delta);
        end
        wd = (wr_data_q.size() > 0) ? wr_data_q[0] : 16'hxxxx;
        checks++;
        if (wd !== 16'h0029) begin
            errors++;
            $display("FAIL cmd_data_o: got %h required 0029", wd);
        end
        checks++;
        if (wr_pulses != 1 || rd_pulses != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL cmd_pulses: wr=%0d rd=%0d words=%0d required 1 0 0",
                     wr_pulses, rd_pulses, got_q.size());
        end
        checks++;
        if (viol_oe + viol_wrrd + viol_cs + viol_rs + viol_len != 0) begin
            errors++;
            $display("FAIL cmd_protocol: oe=%0d wrrd=%0d cs=%0d rs=%0d len=%0d required all 0",
                     viol_oe, viol_wrrd, viol_cs, viol_rs, viol_len);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int d0, gap, d1;
        logic [15:0] w0, w1;
        for (int i = 0; i < 16; i++) panel_mem[i] = 16'h5A00 + 16'(i);
        clear_mon();
        @(posedge clk);
        #1;
        req_cmd = 16'h0011; req_count = 4'd1; req_dummy = 1'b0; req_valid = 1'b1;
        n = 0;
        while (acc_q.size() < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_cmd = 16'h0022; req_count = 4'd0; req_dummy = 1'b1;
        n = 0;
        while (acc_q.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done(2, 30);
        d0  = (acc_q.size() > 0 && done_q.size() > 0) ? done_q[0] - acc_q[0] : -1;
        gap = (acc_q.size() > 1 && done_q.size() > 0) ? acc_q[1] - done_q[0] : -1;
        d1  = (acc_q.size() > 1 && done_q.size() > 1) ? done_q[1] - acc_q[1] : -1;
        checks++;
        if (d0 != 14) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d required 14", d0);
        end
        checks++;
        if (gap != 1) begin
            errors++;
            $display("FAIL b2b_accept_gap: got %0d required 1", gap);
        end
        checks++;
        if (d1 != 6) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d required 6", d1);
        end
        w0 = (wr_data_q.size() > 0) ? wr_data_q[0] : 16'hxxxx;
        w1 = (wr_data_q.size() > 1) ? wr_data_q[1] : 16'hxxxx;
        checks++;
        if (w0 !== 16'h0011 || w1 !== 16'h0022) begin
            errors++;
            $display("FAIL b2b_cmd_latched: got %h %h required 0011 0022", w0, w1);
        end
        checks++;
        if (rd_pulses != 1 || got_q.size() != 1) begin
            errors++;
            $display("FAIL b2b_reads: rd=%0d words=%0d required 1 1", rd_pulses, got_q.size());
        end
    endtask

    task automatic test_max_count();
        int          delta;
        logic [15:0] obs;
        for (int i = 0; i < 16; i++) panel_mem[i] = 16'h1000 + 16'(i);
        clear_mon();
        issue(16'h002E, 4'd15, 1'b0);
        wait_done(1, 200);
        checks++;
        if (got_q.size() != 15 || rd_pulses != 15) begin
            errors++;
            $display("FAIL max_count: words=%0d rd=%0d required 15 15", got_q.size(), rd_pulses);
        end
        for (int i = 0; i < 15; i++) begin
            obs = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            checks++;
            if (obs !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL max_word%0d: got %h required %h", i, obs, 16'h1000 + 16'(i));
            end
        end
        delta = (done_q.size() > 0 && acc_q.size() > 0) ? done_q[0] - acc_q[0] : -1;
        checks++;
        if (delta != 126) begin
            errors++;
            $display("FAIL max_latency: got %0d required 126", delta);
        end
        checks++;
        if (viol_oe + viol_wrrd + viol_cs + viol_rs + viol_len != 0) begin
            errors++;
            $display("FAIL max_protocol: oe=%0d wrrd=%0d cs=%0d rs=%0d len=%0d required all 0",
                     viol_oe, viol_wrrd, viol_cs, viol_rs, viol_len);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) panel_mem[i] = '0;
        test_reset();
        test_abort();
        test_read_dummy();
        test_cmd_only();
        test_back_to_back();
        test_max_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
